// File: rtl/hdl_ram_pipe_pkg.sv
// Shared types, defaults and helpers for the hdl_ram_pipe RAM block.
package hdl_ram_pkg;

  localparam int DEF_WIDTH  = 272;
  localparam int DEF_DEPTH  = 141;
  localparam int DEF_RD_LAT = 3;

  // CLEAR zeroes the array after reset; READY serves the ports.
  typedef enum logic {CLEAR, READY} ram_state_t;

  // Address width for a given number of words.
  function automatic int ram_addr_w(int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hdl_ram_pipe_if.sv
// Port bundle for hdl_ram_pipe: write port, read port, read-valid and busy.
// master = the datapath driving the RAM, slave = the RAM itself.
interface hdl_ram_pipe_if
  import hdl_ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = ram_addr_w(DEPTH);

  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WIDTH-1:0]  dina;
  logic              rd_en;
  logic [ADDR_W-1:0] addrb;
  logic [WIDTH-1:0]  doutb;
  logic              rd_valid;
  logic              busy;

  modport master (
    output wea, addra, dina, rd_en, addrb,
    input  doutb, rd_valid, busy
  );

  modport slave (
    input  wea, addra, dina, rd_en, addrb,
    output doutb, rd_valid, busy
  );

endinterface

// File: rtl/hdl_ram_pipe_rd_pipe.sv
// ram_rd_pipe: generic data + valid shift pipeline of STAGES registers.
// Stage 1 captures the input; the last stage is the visible output register.
// Data registers only load when the valid entering them is set, so the
// output holds its last valid word while the valid bit is low.
module ram_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [STAGES:1]            vld_pipe_q;
  logic [STAGES:1][WIDTH-1:0] dat_pipe_q;

  // Shift valid every cycle; move data only alongside a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q[1] <= in_vld_i;
      if (in_vld_i) dat_pipe_q[1] <= in_data_i;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  assign out_vld_o  = vld_pipe_q[STAGES];
  assign out_data_o = dat_pipe_q[STAGES];

endmodule

// File: rtl/hdl_ram_pipe.sv
// hdl_ram_pipe: simple-dual-port RAM with a zero-clear FSM after reset and a
// registered read pipeline of RD_LAT stages carrying a read-valid bit.
// Optional macro HDL_RAM_WR_FWD_EN: same-address write/read in one cycle
// returns the new write data (write-first). Without it the read returns the
// old contents (read-first) and no bypass mux exists, keeping the array
// mappable onto block RAM.
module hdl_ram_pipe
  import hdl_ram_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic           clk,
  input  logic           rst,
  hdl_ram_pipe_if.slave  bus
);

  localparam int                ADDR_W    = ram_addr_w(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  ram_state_t        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;

  logic              ready;
  logic              addra_ok;
  logic              addrb_ok;

  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [WIDTH-1:0]  wr_data_d;

  logic              rd_req_d;
  logic [WIDTH-1:0]  rd_data_d;

  // Port accesses only count in READY and never in a reset cycle.
  assign ready    = (state_q == READY) && !rst;
  assign addra_ok = {1'b0, bus.addra} < DEPTH_C;
  assign addrb_ok = {1'b0, bus.addrb} < DEPTH_C;

  // Clear FSM: DEPTH cycles of zero writes after every reset, then READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q   <= READY;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        READY: begin
          state_q <= READY;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= CLEAR;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Single write port shared between the clear sweep and the user port;
  // out-of-range user writes are dropped.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = bus.addra;
    wr_data_d = bus.dina;
    if (!rst && state_q == CLEAR) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_cnt_q;
      wr_data_d = '0;
    end else if (ready && bus.wea && addra_ok) begin
      wr_en_d   = 1'b1;
    end
  end

  // Storage array; no reset, the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en_d) mem[wr_addr_d] <= wr_data_d;
  end

  // Stage-1 read data: old array contents (out-of-range reads give zero),
  // optionally bypassed by a same-cycle write to the same word.
  always_comb begin
    rd_req_d  = bus.rd_en && ready;
    rd_data_d = addrb_ok ? mem[bus.addrb] : '0;
`ifdef HDL_RAM_WR_FWD_EN
    if (bus.wea && addra_ok && (bus.addra == bus.addrb)) rd_data_d = bus.dina;
`endif
  end

  ram_rd_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_vld_i   (rd_req_d),
    .in_data_i  (rd_data_d),
    .out_vld_o  (bus.rd_valid),
    .out_data_o (bus.doutb)
  );

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_hdl_ram_pipe.sv
// Self-checking bench for hdl_ram_pipe: default build (272x141, RD_LAT=3)
// plus two 16x4 instances (RD_LAT=1 and 5) driven with identical random
// traffic. Expected read data is pushed to per-instance queues at issue time
// and popped by negedge monitors when rd_valid appears.
module tb_hdl_ram_pipe;

  typedef struct { logic [271:0] data; int due; } exp_m_t;
  typedef struct { logic [15:0]  data; int due; } exp_s_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en   = 1'b0;
  bit mon_s_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  hdl_ram_pipe_if #(.WIDTH(272), .DEPTH(141)) bm ();
  hdl_ram_pipe_if #(.WIDTH(16),  .DEPTH(4))   b1 ();
  hdl_ram_pipe_if #(.WIDTH(16),  .DEPTH(4))   b5 ();

  hdl_ram_pipe #(.WIDTH(272), .DEPTH(141), .RD_LAT(3)) u_dut (.clk(clk), .rst(rst),   .bus(bm));
  hdl_ram_pipe #(.WIDTH(16),  .DEPTH(4),   .RD_LAT(1)) u_s1  (.clk(clk), .rst(rst_s), .bus(b1));
  hdl_ram_pipe #(.WIDTH(16),  .DEPTH(4),   .RD_LAT(5)) u_s5  (.clk(clk), .rst(rst_s), .bus(b5));

  logic [271:0] mm [141];
  logic [15:0]  ms [4];
  exp_m_t qm [$];
  exp_s_t q1 [$];
  exp_s_t q5 [$];
  logic [271:0] hold_m = '0;
  logic [15:0]  hold_1 = '0;
  logic [15:0]  hold_5 = '0;
  bit pend_m = 1'b0;
  bit pend_s = 1'b0;

  // Main-instance scoreboard monitor.
  always @(negedge clk) begin
    exp_m_t e;
    if (pend_m) begin qm.delete(); hold_m = '0; end
    pend_m = rst;
    if (mon_en) begin
      if (bm.rd_valid === 1'b1) begin
        n_vec++;
        if (qm.size() == 0) begin
          n_err++; $display("FAIL main_spurious_valid cyc=%0d doutb=%h", cyc, bm.doutb);
        end else begin
          e = qm.pop_front(); hold_m = e.data;
          if (bm.doutb !== e.data || cyc != e.due) begin
            n_err++;
            $display("FAIL main_read cyc=%0d due=%0d doutb=%h want=%h", cyc, e.due, bm.doutb, e.data);
          end
        end
      end else begin
        if (qm.size() > 0 && qm[0].due <= cyc) begin
          n_vec++; n_err++;
          $display("FAIL main_missing_valid cyc=%0d due=%0d rd_valid=%b want=1", cyc, qm[0].due, bm.rd_valid);
          void'(qm.pop_front());
        end
        n_vec++;
        if (bm.doutb !== hold_m) begin
          n_err++; $display("FAIL main_hold cyc=%0d doutb=%h want=%h", cyc, bm.doutb, hold_m);
        end
      end
    end
  end

  // Small-instance monitors (RD_LAT=1 and RD_LAT=5).
  always @(negedge clk) begin
    exp_s_t e;
    if (pend_s) begin q1.delete(); q5.delete(); hold_1 = '0; hold_5 = '0; end
    pend_s = rst_s;
    if (mon_s_en) begin
      if (b1.rd_valid === 1'b1) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++; $display("FAIL s1_spurious_valid cyc=%0d doutb=%h", cyc, b1.doutb);
        end else begin
          e = q1.pop_front(); hold_1 = e.data;
          if (b1.doutb !== e.data || cyc != e.due) begin
            n_err++; $display("FAIL s1_read cyc=%0d due=%0d doutb=%h want=%h", cyc, e.due, b1.doutb, e.data);
          end
        end
      end else begin
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          n_vec++; n_err++;
          $display("FAIL s1_missing_valid cyc=%0d due=%0d rd_valid=%b want=1", cyc, q1[0].due, b1.rd_valid);
          void'(q1.pop_front());
        end
        n_vec++;
        if (b1.doutb !== hold_1) begin
          n_err++; $display("FAIL s1_hold cyc=%0d doutb=%h want=%h", cyc, b1.doutb, hold_1);
        end
      end
      if (b5.rd_valid === 1'b1) begin
        n_vec++;
        if (q5.size() == 0) begin
          n_err++; $display("FAIL s5_spurious_valid cyc=%0d doutb=%h", cyc, b5.doutb);
        end else begin
          e = q5.pop_front(); hold_5 = e.data;
          if (b5.doutb !== e.data || cyc != e.due) begin
            n_err++; $display("FAIL s5_read cyc=%0d due=%0d doutb=%h want=%h", cyc, e.due, b5.doutb, e.data);
          end
        end
      end else begin
        if (q5.size() > 0 && q5[0].due <= cyc) begin
          n_vec++; n_err++;
          $display("FAIL s5_missing_valid cyc=%0d due=%0d rd_valid=%b want=1", cyc, q5[0].due, b5.rd_valid);
          void'(q5.pop_front());
        end
        n_vec++;
        if (b5.doutb !== hold_5) begin
          n_err++; $display("FAIL s5_hold cyc=%0d doutb=%h want=%h", cyc, b5.doutb, hold_5);
        end
      end
    end
  end

  // One cycle of main-port stimulus; reads push their expected word.
  task automatic drive(input bit we, input int wa, input logic [271:0] wd, input bit re, input int ra);
    exp_m_t e;
    @(posedge clk); #1;
    bm.wea = we; bm.addra = 8'(wa); bm.dina = wd; bm.rd_en = re; bm.addrb = 8'(ra);
    if (re) begin
      e.data = (ra < 141) ? mm[ra] : '0;
`ifdef HDL_RAM_WR_FWD_EN
      if (we && wa == ra && wa < 141) e.data = wd;
`endif
      e.due = cyc + 3;
      qm.push_back(e);
    end
    if (we && wa < 141) mm[wa] = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, '0, 1'b0, 0);
  endtask

  // One-cycle reset pulse on the main instance; model follows the clear.
  task automatic pulse_rst();
    @(posedge clk); #1;
    bm.wea = 1'b0; bm.rd_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 141; i++) mm[i] = '0;
  endtask

  // Counts busy samples until READY (bounded); drops any held port requests.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bm.busy !== 1'b1) begin bm.rd_en = 1'b0; bm.wea = 1'b0; break; end
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    bm.wea = 1'b0; bm.rd_en = 1'b0; bm.addra = '0; bm.addrb = '0; bm.dina = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 141; i++) mm[i] = '0;
    mon_en = 1'b1;
    @(negedge clk);
    n_vec += 3;
    if (bm.doutb !== '0)    begin n_err++; $display("FAIL reset_doutb got=%h want=0", bm.doutb); end
    if (bm.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b want=0", bm.rd_valid); end
    if (bm.busy !== 1'b1)   begin n_err++; $display("FAIL reset_busy got=%b want=1", bm.busy); end
    wait_ready(cnt);
    n_vec++;
    if (cnt + 1 != 141) begin n_err++; $display("FAIL reset_busy_len got=%0d want=141", cnt + 1); end
  endtask

  task automatic test_latency();
    drive(1'b1, 5, {34{8'hA5}}, 1'b0, 0);
    drive(1'b1, 6, 272'd1, 1'b0, 0);
    drive(1'b0, 0, '0, 1'b1, 5);
    drive(1'b0, 0, '0, 1'b1, 6);
    idle(6);
    @(negedge clk);
    n_vec++;
    if (bm.rd_valid !== 1'b0 || bm.doutb !== 272'd1) begin
      n_err++; $display("FAIL latency_hold rd_valid=%b doutb=%h want 0/1", bm.rd_valid, bm.doutb);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 7, 272'h11, 1'b0, 0);
    drive(1'b1, 7, 272'h22, 1'b1, 7);
    drive(1'b0, 0, '0, 1'b1, 7);
    idle(5);
    @(negedge clk);
    n_vec++;
    if (bm.doutb !== 272'h22) begin n_err++; $display("FAIL collision_followup doutb=%h want=22", bm.doutb); end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 200, 272'hFF, 1'b0, 0);
    drive(1'b0, 0, '0, 1'b1, 200);
    drive(1'b0, 0, '0, 1'b1, 59);
    drive(1'b0, 0, '0, 1'b1, 72);
    drive(1'b0, 0, '0, 1'b1, 8);
    idle(5);
  endtask

  task automatic test_clear();
    int cnt;
    pulse_rst();
    bm.wea = 1'b1; bm.addra = 8'd3; bm.dina = '1; bm.rd_en = 1'b1; bm.addrb = 8'd5;
    wait_ready(cnt);
    n_vec++;
    if (cnt != 141) begin n_err++; $display("FAIL clear_busy_len got=%0d want=141", cnt); end
    for (int a = 0; a < 141; a++) drive(1'b0, 0, '0, 1'b1, a);
    idle(5);
  endtask

  task automatic test_rst_mid();
    int cnt;
    int nv;
    pulse_rst();
    repeat (70) @(negedge clk);
    n_vec++;
    if (bm.busy !== 1'b1) begin n_err++; $display("FAIL midclear_busy got=%b want=1", bm.busy); end
    pulse_rst();
    wait_ready(cnt);
    n_vec++;
    if (cnt != 141) begin n_err++; $display("FAIL midclear_restart_len got=%0d want=141", cnt); end
    drive(1'b1, 9, {34{8'h3C}}, 1'b0, 0);
    drive(1'b0, 0, '0, 1'b1, 9);
    drive(1'b0, 0, '0, 1'b1, 9);
    pulse_rst();
    nv = 0;
    repeat (6) begin @(negedge clk); if (bm.rd_valid !== 1'b0) nv++; end
    n_vec++;
    if (nv != 0) begin n_err++; $display("FAIL inflight_flush valid_count=%0d want=0", nv); end
    wait_ready(cnt);
    drive(1'b0, 0, '0, 1'b1, 9);
    idle(5);
  endtask

  task automatic drive_s(input bit we, input int wa, input logic [15:0] wd, input bit re, input int ra);
    exp_s_t e;
    @(posedge clk); #1;
    b1.wea = we; b1.addra = 2'(wa); b1.dina = wd; b1.rd_en = re; b1.addrb = 2'(ra);
    b5.wea = we; b5.addra = 2'(wa); b5.dina = wd; b5.rd_en = re; b5.addrb = 2'(ra);
    if (re) begin
      e.data = ms[ra];
`ifdef HDL_RAM_WR_FWD_EN
      if (we && wa == ra) e.data = wd;
`endif
      e.due = cyc + 1; q1.push_back(e);
      e.due = cyc + 5; q5.push_back(e);
    end
    if (we) ms[wa] = wd;
  endtask

  task automatic test_sweep();
    int c1;
    int c5;
    b1.wea = 1'b0; b1.rd_en = 1'b0; b5.wea = 1'b0; b5.rd_en = 1'b0;
    @(posedge clk); #1 rst_s = 1'b1;
    @(posedge clk); #1 rst_s = 1'b0;
    for (int i = 0; i < 4; i++) ms[i] = '0;
    mon_s_en = 1'b1;
    c1 = 0; c5 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b1.busy === 1'b1) c1++;
      if (b5.busy === 1'b1) c5++;
      if (b1.busy !== 1'b1 && b5.busy !== 1'b1) break;
    end
    n_vec += 2;
    if (c1 != 4) begin n_err++; $display("FAIL sweep_busy_lat1 got=%0d want=4", c1); end
    if (c5 != 4) begin n_err++; $display("FAIL sweep_busy_lat5 got=%0d want=4", c5); end
    for (int i = 0; i < 300; i++)
      drive_s(1'($urandom_range(0, 1)), $urandom_range(0, 3), 16'($urandom),
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    repeat (8) drive_s(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic test_drain();
    repeat (3) @(negedge clk);
    n_vec++;
    if (qm.size() + q1.size() + q5.size() != 0) begin
      n_err++; $display("FAIL drain_queues left=%0d want=0", qm.size() + q1.size() + q5.size());
    end
  endtask

  initial begin
    b1.wea = 1'b0; b1.rd_en = 1'b0; b1.addra = '0; b1.addrb = '0; b1.dina = '0;
    b5.wea = 1'b0; b5.rd_en = 1'b0; b5.addra = '0; b5.addrb = '0; b5.dina = '0;
    test_reset();
    test_latency();
    test_collision();
    test_out_of_range();
    test_clear();
    test_rst_mid();
    test_sweep();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
